ceespu_lsu: RTL and testbench
=============================

CEESPU_LSU -- requirements
Module: ceespu_lsu

Interface
REQ-001 I_clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 I_rst  in  1  reset; asynchronous, active-low (0 = reset).
REQ-003 I_valid  in  1  decode presents a memory op this cycle.
REQ-004 I_load / I_store  in  1 each  op kind; both high = illegal.
REQ-005 I_size  in  2  0=word, 1=half, 2=byte, 3=illegal.
REQ-006 I_signed  in  1  sign-extend load result (drives O_selMem[3]).
REQ-007 I_base  in  32  base register value.
REQ-008 I_offset  in  16  signed immediate offset.
REQ-009 I_storeData  in  32  store source register value.
REQ-010 O_req  out  1  bus request, held until ack or timeout.
REQ-011 O_wr  out  1  1 = write cycle.
REQ-012 O_addr  out  32  word-aligned bus address, {ea[31:2],2'b00}.
REQ-013 O_be  out  4  byte enables (bit0 = byte [7:0]).
REQ-014 O_wdata  out  32  lane-replicated store data.
REQ-015 I_ack  in  1  bus completion; I_rdata valid in the same cycle.
REQ-016 I_rdata  in  32  bus read word.
REQ-017 O_memA  out  32  captured read word, fed to execute as I_memA.
REQ-018 O_selMem  out  4  lane/sign select, fed to execute as I_selMem.
REQ-019 O_busy  out  1  stall upstream; high while an access is outstanding.
REQ-020 O_done  out  1  one-cycle pulse on successful completion.
REQ-021 O_fault  out  1  one-cycle pulse on misalign, illegal op, or timeout.

Function
REQ-022 ea = I_base + sign-extended I_offset, modulo 2^32; carry-out discarded.
REQ-023 The FSM SHALL have states IDLE and ACCESS; reset state is IDLE.
REQ-024 Accept: IDLE & I_valid & (I_load|I_store) -> latch ea, size, sign, wr, data; next cycle O_req=1, O_busy=1, state ACCESS.
REQ-025 Illegal (I_load&I_store, or I_size=3) or misaligned (half with ea[0]=1; word with ea[1:0]!=0) -> no bus cycle; O_fault=1 next cycle; stay IDLE.
REQ-026 I_valid with neither I_load nor I_store SHALL be ignored.
REQ-027 I_valid while in ACCESS SHALL be ignored; upstream holds the op using O_busy.
REQ-028 O_wr, O_addr, O_be, O_wdata SHALL remain stable while O_req=1.
REQ-029 O_be: word 4'b1111; half ea[1]=0 -> 4'b0011, ea[1]=1 -> 4'b1100; byte 4'b0001 << ea[1:0]; loads use the same enables.
REQ-030 O_wdata: word = data; half = {2{data[15:0]}}; byte = {4{data[7:0]}}.
REQ-031 O_selMem[2:0]: word 3'b000; half {2'b01,ea[1]}; byte {1'b1,ea[1:0]}; O_selMem[3] = latched I_signed; updated only at accept.
REQ-032 ACCESS & I_ack: O_req, O_busy drop at that edge; O_done=1 for one cycle; load captures I_rdata into O_memA; state IDLE.
REQ-033 A store SHALL NOT modify O_memA.
REQ-034 A 4-bit wait counter SHALL clear at accept and increment each ACCESS cycle without I_ack.
REQ-035 16 ACCESS cycles without I_ack -> O_req, O_busy drop; O_fault pulse; O_memA unchanged; state IDLE.
REQ-036 I_ack in the same cycle the counter saturates SHALL count as success, not timeout.
REQ-037 I_ack while in IDLE SHALL be ignored.
REQ-038 Back-to-back: a new accept is possible in the cycle after return to IDLE (minimum 2-cycle access: accept, ack).

Reset
REQ-039 I_rst=0 SHALL immediately force state IDLE and O_req, O_wr, O_busy, O_done, O_fault, O_be, counter to 0, and O_addr, O_wdata, O_memA, O_selMem to 0.
REQ-040 Reset mid-access SHALL abandon the access with no O_done or O_fault; the first accept is possible on the first edge after I_rst returns to 1.

Verification
REQ-041 Word load, base=0x100, offset=-4, ack after 2 waits, rdata=0xDEADBEEF -> O_addr=0xFC, O_be=1111, O_selMem=0000, O_memA=0xDEADBEEF, one O_done.
REQ-042 Signed byte load, ea=0x203 -> O_be=1000, O_selMem=1111; byte store 0xA5 at ea=0x201 -> O_be=0010, O_wdata=0xA5A5A5A5, O_wr=1, O_memA unchanged.
REQ-043 Half load, ea=0x102 -> O_be=1100, O_selMem=x011 per I_signed; half at ea=0x101 -> no O_req, O_fault pulse next cycle.
REQ-044 No ack for 16 cycles -> O_req drops, O_fault pulse, O_busy low; ack on the 16th cycle -> O_done instead.
REQ-045 Assert I_rst=0 during ACCESS -> all outputs zero immediately, no done/fault; new load accepted after release.
REQ-046 I_load=I_store=1 or I_size=3 -> O_fault, no O_req; I_valid during ACCESS -> ignored, no second bus cycle.

Source files
------------

// File: rtl/ceespu_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : ceespu_lsu
//  Purpose  : Load/store unit. Forms the effective address, validates the
//             operation (legal kind/size, natural alignment), then drives
//             one word-aligned bus transaction with byte enables and
//             lane-replicated write data. It waits up to 16 cycles for an
//             acknowledge before giving up. Read data and the lane/sign
//             select are handed to the execute stage.
//  Ports    : I_clk, I_rst (async, active-low)
//             I_valid, I_load, I_store, I_size, I_signed   - op from decode
//             I_base, I_offset, I_storeData                - operands
//             O_req, O_wr, O_addr, O_be, O_wdata           - bus request
//             I_ack, I_rdata                               - bus response
//             O_memA, O_selMem                             - to execute
//             O_busy, O_done, O_fault                      - status
//  Revision : 1.0 - initial release
// ============================================================================
module ceespu_lsu (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_valid,
  input  logic        I_load,
  input  logic        I_store,
  input  logic [1:0]  I_size,
  input  logic        I_signed,
  input  logic [31:0] I_base,
  input  logic [15:0] I_offset,
  input  logic [31:0] I_storeData,
  output logic        O_req,
  output logic        O_wr,
  output logic [31:0] O_addr,
  output logic [3:0]  O_be,
  output logic [31:0] O_wdata,
  input  logic        I_ack,
  input  logic [31:0] I_rdata,
  output logic [31:0] O_memA,
  output logic [3:0]  O_selMem,
  output logic        O_busy,
  output logic        O_done,
  output logic        O_fault
);

  localparam logic [1:0] c_SIZE_WORD = 2'd0;
  localparam logic [1:0] c_SIZE_HALF = 2'd1;
  localparam logic [1:0] c_SIZE_BYTE = 2'd2;
  localparam logic [1:0] c_SIZE_ILL  = 2'd3;
  localparam logic [3:0] c_WAIT_LAST = 4'd15;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t      r_state;
  logic [3:0]  r_wait;

  logic [31:0] w_ea;
  logic        w_start;
  logic        w_illegal;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [2:0]  w_sel;

  // Offset is sign-extended; the 32-bit add wraps and drops its carry.
  assign w_ea       = I_base + {{16{I_offset[15]}}, I_offset};
  assign w_start    = I_valid & (I_load | I_store);
  assign w_illegal  = (I_load & I_store) | (I_size == c_SIZE_ILL);
  assign w_misalign = ((I_size == c_SIZE_HALF) & w_ea[0]) |
                      ((I_size == c_SIZE_WORD) & (w_ea[1:0] != 2'b00));

  // Lane decode. Loads use the same enables as stores, so the bus sees
  // exactly the bytes being accessed.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = I_storeData;
    w_sel   = 3'b000;
    case (I_size)
      c_SIZE_WORD: begin
        w_be    = 4'b1111;
        w_wdata = I_storeData;
        w_sel   = 3'b000;
      end
      c_SIZE_HALF: begin
        w_be    = w_ea[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{I_storeData[15:0]}};
        w_sel   = {2'b01, w_ea[1]};
      end
      c_SIZE_BYTE: begin
        w_be    = 4'b0001 << w_ea[1:0];
        w_wdata = {4{I_storeData[7:0]}};
        w_sel   = {1'b1, w_ea[1:0]};
      end
      default: begin
        w_be    = 4'b0000;
        w_wdata = I_storeData;
        w_sel   = 3'b000;
      end
    endcase
  end

  // Bus outputs are only written at accept, so they hold steady for the
  // whole request. O_wr also tells the ack path whether to capture data.
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      r_state  <= ST_IDLE;
      r_wait   <= 4'd0;
      O_req    <= 1'b0;
      O_wr     <= 1'b0;
      O_addr   <= 32'd0;
      O_be     <= 4'd0;
      O_wdata  <= 32'd0;
      O_memA   <= 32'd0;
      O_selMem <= 4'd0;
      O_busy   <= 1'b0;
      O_done   <= 1'b0;
      O_fault  <= 1'b0;
    end else begin
      O_done  <= 1'b0;
      O_fault <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            if (w_illegal | w_misalign) begin
              O_fault <= 1'b1;
            end else begin
              O_req    <= 1'b1;
              O_busy   <= 1'b1;
              O_wr     <= I_store;
              O_addr   <= {w_ea[31:2], 2'b00};
              O_be     <= w_be;
              O_wdata  <= w_wdata;
              O_selMem <= {I_signed, w_sel};
              r_wait   <= 4'd0;
              r_state  <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          // Ack takes priority, so an ack on the final wait cycle succeeds.
          if (I_ack) begin
            O_req   <= 1'b0;
            O_busy  <= 1'b0;
            O_done  <= 1'b1;
            if (!O_wr) begin
              O_memA <= I_rdata;
            end
            r_state <= ST_IDLE;
          end else if (r_wait == c_WAIT_LAST) begin
            O_req   <= 1'b0;
            O_busy  <= 1'b0;
            O_fault <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ceespu_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ceespu_lsu
//  Purpose  : Self-checking bench for ceespu_lsu: directed vector table,
//             hand-written reset/ignore sequences, and randomized ops
//             checked against a byte-range reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ceespu_lsu;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic        I_valid, I_load, I_store, I_signed, I_ack;
  logic [1:0]  I_size;
  logic [31:0] I_base, I_storeData, I_rdata;
  logic [15:0] I_offset;
  logic        O_req, O_wr, O_busy, O_done, O_fault;
  logic [31:0] O_addr, O_wdata, O_memA;
  logic [3:0]  O_be, O_selMem;

  ceespu_lsu dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_valid(I_valid), .I_load(I_load),
    .I_store(I_store), .I_size(I_size), .I_signed(I_signed),
    .I_base(I_base), .I_offset(I_offset), .I_storeData(I_storeData),
    .O_req(O_req), .O_wr(O_wr), .O_addr(O_addr), .O_be(O_be),
    .O_wdata(O_wdata), .I_ack(I_ack), .I_rdata(I_rdata), .O_memA(O_memA),
    .O_selMem(O_selMem), .O_busy(O_busy), .O_done(O_done), .O_fault(O_fault)
  );

  always #5 I_clk = ~I_clk;

  typedef struct {
    logic        ld, st;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] base;
    logic [15:0] off;
    logic [31:0] data;
    int          waits;   // ACCESS cycles before ack; >= 16 means never
    logic [31:0] rdata;
    logic        e_fault; // immediate fault, no bus cycle
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [3:0]  e_sel;
    logic [31:0] e_memA;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_memA;
  vec_t        tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic ld, st, input logic [1:0] size, input logic sgn,
                               input logic [31:0] base, input logic [15:0] off,
                               input logic [31:0] data, input int waits,
                               input logic [31:0] rdata, input logic e_fault,
                               input logic [31:0] e_addr, input logic [3:0] e_be,
                               input logic [31:0] e_wdata, input logic [3:0] e_sel,
                               input logic [31:0] e_memA);
    vec_t v;
    v.ld = ld; v.st = st; v.size = size; v.sgn = sgn; v.base = base; v.off = off;
    v.data = data; v.waits = waits; v.rdata = rdata; v.e_fault = e_fault;
    v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata; v.e_sel = e_sel;
    v.e_memA = e_memA;
    return v;
  endfunction

  // Reference: an access covers bytes [lane, lane+nbytes) of one word.
  function automatic vec_t model(input vec_t v, input logic [31:0] mem);
    logic [31:0] ea;
    int          nb, lane;
    logic [2:0]  s;
    ea   = v.base + {{16{v.off[15]}}, v.off};
    nb   = (v.size == 2'd0) ? 4 : (v.size == 2'd1) ? 2 : 1;
    lane = int'(ea[1:0]);
    v.e_fault = (v.ld && v.st) || (v.size == 2'd3) || ((lane % nb) != 0);
    v.e_addr  = ea - 32'(lane);
    for (int i = 0; i < 4; i++) begin
      v.e_be[i] = (i >= lane) && (i < lane + nb);
      v.e_wdata[8*i +: 8] = v.data[8*(i % nb) +: 8];
    end
    if (nb == 4)      s = 3'd0;
    else if (nb == 2) s = 3'(2 + lane / 2);
    else              s = 3'(4 + lane);
    v.e_sel  = {v.sgn, s};
    v.e_memA = (!v.e_fault && v.waits < 16 && v.ld) ? v.rdata : mem;
    return v;
  endfunction

  // Called just after a negedge; returns just after a negedge.
  task automatic run_op(input vec_t v, input string tag);
    bit acked;
    I_valid = 1'b1; I_load = v.ld; I_store = v.st; I_size = v.size;
    I_signed = v.sgn; I_base = v.base; I_offset = v.off; I_storeData = v.data;
    I_ack = 1'b0;
    @(negedge I_clk);
    // Scramble operands to prove the unit latched them.
    I_valid = 1'b0; I_load = 1'($urandom); I_store = 1'($urandom);
    I_size = 2'($urandom); I_base = $urandom; I_offset = 16'($urandom);
    I_storeData = $urandom; I_signed = 1'($urandom);
    if (v.e_fault) begin
      chk({tag, ".fault"}, 32'(O_fault), 32'd1);
      chk({tag, ".req_nf"}, 32'(O_req), 32'd0);
      chk({tag, ".busy_nf"}, 32'(O_busy), 32'd0);
      chk({tag, ".done_nf"}, 32'(O_done), 32'd0);
      // Stray ack while idle must be ignored.
      I_ack = 1'b1; I_rdata = $urandom;
      @(negedge I_clk);
      I_ack = 1'b0;
      chk({tag, ".fault_pulse"}, 32'(O_fault), 32'd0);
      chk({tag, ".done_idle_ack"}, 32'(O_done), 32'd0);
      chk({tag, ".memA_idle_ack"}, O_memA, v.e_memA);
    end else begin
      chk({tag, ".req"}, 32'(O_req), 32'd1);
      chk({tag, ".busy"}, 32'(O_busy), 32'd1);
      chk({tag, ".wr"}, 32'(O_wr), 32'(v.st));
      chk({tag, ".addr"}, O_addr, v.e_addr);
      chk({tag, ".be"}, 32'(O_be), 32'(v.e_be));
      chk({tag, ".wdata"}, O_wdata, v.e_wdata);
      chk({tag, ".sel"}, 32'(O_selMem), 32'(v.e_sel));
      chk({tag, ".done0"}, 32'(O_done), 32'd0);
      chk({tag, ".fault0"}, 32'(O_fault), 32'd0);
      acked = 1'b0;
      for (int k = 0; k < 16 && !acked; k++) begin
        I_ack   = (k == v.waits);
        I_rdata = I_ack ? v.rdata : $urandom;
        I_valid = 1'($urandom); I_load = 1'b1; I_store = 1'b0;
        I_size = 2'd0; I_base = 32'h0; I_offset = 16'h0;
        @(negedge I_clk);
        I_ack = 1'b0; I_valid = 1'b0;
        if (k == v.waits) begin
          acked = 1'b1;
          chk({tag, ".done"}, 32'(O_done), 32'd1);
          chk({tag, ".req_drop"}, 32'(O_req), 32'd0);
          chk({tag, ".busy_drop"}, 32'(O_busy), 32'd0);
          chk({tag, ".fault_ack"}, 32'(O_fault), 32'd0);
          chk({tag, ".memA"}, O_memA, v.e_memA);
        end else if (k == 15) begin
          chk({tag, ".tmo_fault"}, 32'(O_fault), 32'd1);
          chk({tag, ".tmo_done"}, 32'(O_done), 32'd0);
          chk({tag, ".tmo_req"}, 32'(O_req), 32'd0);
          chk({tag, ".tmo_busy"}, 32'(O_busy), 32'd0);
          chk({tag, ".tmo_memA"}, O_memA, v.e_memA);
        end else begin
          chk({tag, ".hold_req"}, 32'(O_req), 32'd1);
          chk({tag, ".hold_addr"}, O_addr, v.e_addr);
          chk({tag, ".hold_be"}, 32'(O_be), 32'(v.e_be));
          chk({tag, ".hold_wdata"}, O_wdata, v.e_wdata);
          chk({tag, ".hold_done"}, 32'(O_done | O_fault), 32'd0);
        end
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   r;
    I_rst = 1'b0; I_valid = 1'b0; I_load = 1'b0; I_store = 1'b0; I_size = 2'd0;
    I_signed = 1'b0; I_base = 32'h0; I_offset = 16'h0; I_storeData = 32'h0;
    I_ack = 1'b0; I_rdata = 32'h0;

    //            ld st sz sg base          off      data          w   rdata         f  addr          be     wdata         sel      memA
    tbl[0]  = mkv(1, 0, 0, 0, 32'h100,      16'hFFFC, 32'h12345678, 2,  32'hDEADBEEF, 0, 32'hFC,      4'hF,  32'h12345678, 4'b0000, 32'hDEADBEEF);
    tbl[1]  = mkv(1, 0, 2, 1, 32'h200,      16'h0003, 32'h000000C3, 0,  32'h11223344, 0, 32'h200,     4'h8,  32'hC3C3C3C3, 4'b1111, 32'h11223344);
    tbl[2]  = mkv(0, 1, 2, 0, 32'h1F0,      16'h0011, 32'hFFFFFFA5, 1,  32'h99999999, 0, 32'h200,     4'h2,  32'hA5A5A5A5, 4'b0101, 32'h11223344);
    tbl[3]  = mkv(1, 0, 1, 0, 32'h100,      16'h0002, 32'h0000BEEF, 3,  32'hCAFEF00D, 0, 32'h100,     4'hC,  32'hBEEFBEEF, 4'b0011, 32'hCAFEF00D);
    tbl[4]  = mkv(1, 0, 1, 1, 32'h100,      16'h0002, 32'h00000000, 0,  32'h55AA55AA, 0, 32'h100,     4'hC,  32'h00000000, 4'b1011, 32'h55AA55AA);
    tbl[5]  = mkv(1, 0, 1, 0, 32'h100,      16'h0001, 32'h0,        0,  32'h0,        1, 32'h0,       4'h0,  32'h0,        4'b0000, 32'h55AA55AA);
    tbl[6]  = mkv(0, 1, 0, 0, 32'h100,      16'h0002, 32'h0,        0,  32'h0,        1, 32'h0,       4'h0,  32'h0,        4'b0000, 32'h55AA55AA);
    tbl[7]  = mkv(1, 1, 0, 0, 32'h100,      16'h0000, 32'h0,        0,  32'h0,        1, 32'h0,       4'h0,  32'h0,        4'b0000, 32'h55AA55AA);
    tbl[8]  = mkv(1, 0, 3, 0, 32'h100,      16'h0000, 32'h0,        0,  32'h0,        1, 32'h0,       4'h0,  32'h0,        4'b0000, 32'h55AA55AA);
    tbl[9]  = mkv(0, 1, 0, 0, 32'h400,      16'h0000, 32'h01020304, 16, 32'hFFFFFFFF, 0, 32'h400,     4'hF,  32'h01020304, 4'b0000, 32'h55AA55AA);
    tbl[10] = mkv(1, 0, 0, 1, 32'h3FF,      16'h0001, 32'h0,        15, 32'h87654321, 0, 32'h400,     4'hF,  32'h0,        4'b1000, 32'h87654321);
    tbl[11] = mkv(1, 0, 2, 1, 32'h2,        16'hFFFE, 32'h0,        0,  32'h000000FF, 0, 32'h0,       4'h1,  32'h0,        4'b1100, 32'h000000FF);
    tbl[12] = mkv(0, 1, 0, 0, 32'hFFFFFFFF, 16'h0001, 32'hAAAA5555, 0,  32'h0,        0, 32'h0,       4'hF,  32'hAAAA5555, 4'b0000, 32'h000000FF);

    // Reset state
    repeat (2) @(negedge I_clk);
    chk("rst.req", 32'(O_req), 32'd0);
    chk("rst.busy", 32'(O_busy), 32'd0);
    chk("rst.flags", 32'({O_wr, O_done, O_fault}), 32'd0);
    chk("rst.addr", O_addr, 32'd0);
    chk("rst.be_sel", 32'({O_be, O_selMem}), 32'd0);
    chk("rst.wdata", O_wdata, 32'd0);
    chk("rst.memA", O_memA, 32'd0);
    I_rst = 1'b1;
    m_memA = 32'h0;

    // Directed vectors, back to back
    for (int i = 0; i < 13; i++) begin
      run_op(tbl[i], $sformatf("vec%0d", i));
      m_memA = tbl[i].e_memA;
    end

    // Valid without load/store is ignored
    I_valid = 1'b1; I_load = 1'b0; I_store = 1'b0; I_size = 2'd3; I_base = 32'h1;
    @(negedge I_clk);
    I_valid = 1'b0;
    chk("noop.req", 32'(O_req), 32'd0);
    chk("noop.fault", 32'(O_fault), 32'd0);
    chk("noop.busy", 32'(O_busy), 32'd0);

    // Reset in the middle of a byte store
    I_valid = 1'b1; I_load = 1'b0; I_store = 1'b1; I_size = 2'd2; I_signed = 1'b1;
    I_base = 32'h800; I_offset = 16'h0003; I_storeData = 32'h0000005A;
    @(negedge I_clk);
    I_valid = 1'b0;
    chk("mid.req", 32'(O_req), 32'd1);
    chk("mid.wdata", O_wdata, 32'h5A5A5A5A);
    @(negedge I_clk);
    #2 I_rst = 1'b0;
    #1;
    chk("arst.req_busy", 32'({O_req, O_busy}), 32'd0);
    chk("arst.wr", 32'(O_wr), 32'd0);
    chk("arst.addr", O_addr, 32'd0);
    chk("arst.be", 32'(O_be), 32'd0);
    chk("arst.wdata", O_wdata, 32'd0);
    chk("arst.memA", O_memA, 32'd0);
    chk("arst.sel", 32'(O_selMem), 32'd0);
    I_ack = 1'b1; I_rdata = 32'hFFFF0000;
    @(negedge I_clk);
    I_ack = 1'b0;
    chk("arst.done_fault", 32'({O_done, O_fault}), 32'd0);
    chk("arst.memA_held", O_memA, 32'd0);
    I_rst = 1'b1;
    m_memA = 32'h0;
    v = mkv(1, 0, 0, 0, 32'h10, 16'h0, 32'h0, 1, 32'h0BADF00D, 0, 32'h10, 4'hF, 32'h0, 4'b0000, 32'h0BADF00D);
    run_op(v, "post_rst");
    m_memA = v.e_memA;

    // Randomized ops against the reference model
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom % 8);
      v.ld = (r == 0) || (r < 5);
      v.st = (r == 0) || (r >= 5);
      r = int'($urandom % 10);
      v.size = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      v.sgn   = 1'($urandom);
      v.base  = $urandom;
      v.off   = 16'($urandom);
      if ($urandom % 3 != 0)
        v.base = v.base - ((v.base + {{16{v.off[15]}}, v.off}) & 32'h3);
      v.data  = $urandom;
      v.waits = ($urandom % 6 == 0) ? 13 + int'($urandom % 5) : int'($urandom % 4);
      v.rdata = $urandom;
      v = model(v, m_memA);
      run_op(v, $sformatf("rnd%0d", n));
      m_memA = v.e_memA;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
